// File: rtl/sel_drive_seq.sv
// sel_drive_seq
//   Programmable stimulus driver for a single-bit select line. It plays back
//   a stored program of drive-0 / drive-1 / release steps. Each step is held
//   for hold+1 cycles. At the last cycle of every driven step the line is read
//   back, and any difference from the driven value is flagged.
//
//   Optional feature macro: SEL_DRIVE_LOOP_EN
//     When defined, a 'loop' input is added. With loop=1 at the program end,
//     playback wraps to step 0 without a gap cycle and done pulses at each
//     wrap. Without the macro, playback always terminates in DONE.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   wr_en         program write strobe (accepted only while not busy)
//   wr_addr       program step address
//   wr_data       {mode[1:0], hold}; mode 00=drive0 01=drive1 10=release 11=END
//   wr_err        pulse: write attempted while busy (the write is dropped)
//   start         begin playback from step 0 (honoured only in IDLE)
//   abort         stop playback and release the line
//   loop          (SEL_DRIVE_LOOP_EN only) wrap to step 0 at the program end
//   sel_o, sel_oe drive value and output enable (sel_oe=0 releases the line)
//   sel_i         line readback
//   busy          playback in progress
//   done          one-cycle pulse at completion (or at each wrap when looping)
//   step_idx      index of the current step
//   mismatch      sticky readback-mismatch flag, cleared on start
//   mismatch_cnt  saturating count of mismatching steps, cleared on start

module sel_drive_seq #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [HOLD_W+1:0]        wr_data,
    output logic                     wr_err,
    input  logic                     start,
    input  logic                     abort,
`ifdef SEL_DRIVE_LOOP_EN
    input  logic                     loop,
`endif
    output logic                     sel_o,
    output logic                     sel_oe,
    input  logic                     sel_i,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     mismatch,
    output logic [CNT_W-1:0]         mismatch_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = HOLD_W + 2;

    localparam logic [1:0] MODE_D0  = 2'b00;
    localparam logic [1:0] MODE_D1  = 2'b01;
    localparam logic [1:0] MODE_END = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [W-1:0]      prog [DEPTH];

    logic [W-1:0]  step0;
    logic [W-1:0]  next_step;
    logic [W-1:0]  load_step;
    logic [AW-1:0] next_idx;
    logic          last_step;
    logic          hit;
    logic          wrap;

    // {oe, o} for a step mode; release and END both leave the line undriven.
    function automatic logic [1:0] drive_of(input logic [1:0] m);
        case (m)
            MODE_D0: return 2'b10;
            MODE_D1: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

`ifdef SEL_DRIVE_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    assign busy   = (state == S_RUN);
    assign wr_err = wr_en & busy;

    // Program memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            prog[wr_addr] <= wr_data;
        end
    end

    // A write to step 0 in the same cycle as start must be the data played,
    // so step 0 is bypassed from the write port.
    assign step0     = (wr_en && (wr_addr == '0)) ? wr_data : prog[0];
    assign next_idx  = step_idx + 1'b1;
    assign next_step = prog[next_idx];
    assign last_step = (step_idx == AW'(DEPTH - 1)) ||
                       (next_step[W-1 -: 2] == MODE_END);
    assign hit       = sel_oe && (sel_i != sel_o);
    // When wrapping, step 0 is reloaded; otherwise the following step.
    assign load_step = (last_step && wrap) ? prog[0] : next_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            sel_o        <= 1'b0;
            sel_oe       <= 1'b0;
            done         <= 1'b0;
            step_idx     <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mismatch     <= 1'b0;
                        mismatch_cnt <= '0;
                        step_idx     <= '0;
                        if (step0[W-1 -: 2] == MODE_END) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state            <= S_RUN;
                            {sel_oe, sel_o}  <= drive_of(step0[W-1 -: 2]);
                            hold_cnt         <= step0[HOLD_W-1:0];
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Abort takes priority over the end-of-step compare.
                        state  <= S_IDLE;
                        sel_oe <= 1'b0;
                        sel_o  <= 1'b0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else begin
                        if (hit) begin
                            mismatch <= 1'b1;
                            if (mismatch_cnt != '1) begin
                                mismatch_cnt <= mismatch_cnt + 1'b1;
                            end
                        end
                        if (last_step && !wrap) begin
                            // step_idx keeps the last executed index.
                            state  <= S_DONE;
                            done   <= 1'b1;
                            sel_oe <= 1'b0;
                            sel_o  <= 1'b0;
                        end else begin
                            done            <= last_step;
                            step_idx        <= last_step ? '0 : next_idx;
                            {sel_oe, sel_o} <= drive_of(load_step[W-1 -: 2]);
                            hold_cnt        <= load_step[HOLD_W-1:0];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_drive_seq.sv
// tb_sel_drive_seq
//   Scoreboard bench for sel_drive_seq (default build, no loop port).
//   The stimulus side expands the stored program into a per-cycle list of
//   expected outputs and queues it; the monitor pops one entry per cycle on
//   the falling edge and compares.
//   Ports exercised: all ports of the default build.

module tb_sel_drive_seq;

    localparam int DEPTH  = 8;
    localparam int HOLD_W = 8;
    localparam int CNT_W  = 2;
    localparam int AW     = 3;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [HOLD_W+1:0] wr_data;
    logic              wr_err;
    logic              start;
    logic              abort;
    logic              sel_o;
    logic              sel_oe;
    logic              sel_i;
    logic              busy;
    logic              done;
    logic [AW-1:0]     step_idx;
    logic              mismatch;
    logic [CNT_W-1:0]  mismatch_cnt;

    sel_drive_seq #(
        .DEPTH (DEPTH),
        .HOLD_W(HOLD_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .start       (start),
        .abort       (abort),
        .sel_o       (sel_o),
        .sel_oe      (sel_oe),
        .sel_i       (sel_i),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx),
        .mismatch    (mismatch),
        .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             oe;
        logic             o;
        logic             bsy;
        logic             dn;
        logic [AW-1:0]    idx;
        logic             mm;
        logic [CNT_W-1:0] mc;
        logic             we;
    } ent_t;

    ent_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Line behaviour: 0 follows the driver, 1 stuck at 0, 2 stuck at 1, 3 inverted.
    int policy = 0;
    always_comb begin
        case (policy)
            0:       sel_i = sel_o;
            1:       sel_i = 1'b0;
            2:       sel_i = 1'b1;
            default: sel_i = ~sel_o;
        endcase
    end

    // Reference copy of the program.
    int pm[DEPTH];
    int ph[DEPTH];

    always @(negedge clk) begin
        ent_t e;
        ent_t g;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            g = '{sel_oe, sel_o, busy, done, step_idx, mismatch, mismatch_cnt, wr_err};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL trace t=%0t: got oe=%b o=%b busy=%b done=%b idx=%0d mm=%b cnt=%0d werr=%b, required oe=%b o=%b busy=%b done=%b idx=%0d mm=%b cnt=%0d werr=%b",
                         $time, g.oe, g.o, g.bsy, g.dn, g.idx, g.mm, g.mc, g.we,
                         e.oe, e.o, e.bsy, e.dn, e.idx, e.mm, e.mc, e.we);
            end
        end
    end

    function automatic bit line_bad(int pol, logic v);
        case (pol)
            0:       return 1'b0;
            1:       return v != 1'b0;
            2:       return v != 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic wr_step(input int addr, input int mode, input int hold);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = {2'(mode), HOLD_W'(hold)};
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        pm[addr] = mode;
        ph[addr] = hold;
    endtask

    // ab/wa: cycle (1-based after start) of abort / busy write; -1 picks randomly.
    // ra: cycle in which reset is asserted mid-run. pre: write step 0 with start.
    task automatic run_prog(input int pol, input int ab, input int wa, input int ra,
                            input bit pre, input int pmode, input int phold);
        ent_t tr[$];
        ent_t e;
        logic mm;
        logic [CNT_W-1:0] mc;
        int   last;
        int   nbusy;
        int   i;
        int   n;
        tr    = {};
        mm    = 1'b0;
        mc    = '0;
        last  = 0;
        start = 1'b1;
        if (pre) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = {2'(pmode), HOLD_W'(phold)};
            pm[0]   = pmode;
            ph[0]   = phold;
        end
        if (pm[0] != 3) begin
            i = 0;
            while (1) begin
                for (int k = 0; k <= ph[i]; k++)
                    tr.push_back('{pm[i] != 2, pm[i] == 1, 1'b1, 1'b0, AW'(i), mm, mc, 1'b0});
                if (pm[i] != 2 && line_bad(pol, pm[i] == 1)) begin
                    mm = 1'b1;
                    if (mc != CMAX) mc = mc + 1'b1;
                end
                last = i;
                if (i == DEPTH - 1 || pm[i + 1] == 3) break;
                i++;
            end
        end
        nbusy = tr.size();
        tr.push_back('{1'b0, 1'b0, 1'b0, 1'b1, AW'(last), mm, mc, 1'b0});
        tr.push_back('{1'b0, 1'b0, 1'b0, 1'b0, AW'(last), mm, mc, 1'b0});
        if (ab < 0) ab = (nbusy > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nbusy)) : 0;
        if (wa < 0) wa = (nbusy > 0 && $urandom_range(0, 2) == 0)
                         ? int'($urandom_range(1, (ab > 0) ? ab : nbusy)) : 0;
        if (ab > 0) begin
            e = tr[ab - 1];
            while (tr.size() > ab) void'(tr.pop_back());
            tr.push_back('{1'b0, 1'b0, 1'b0, 1'b0, e.idx, e.mm, e.mc, 1'b0});
        end
        if (wa > 0) begin
            e = tr[wa - 1];
            e.we = 1'b1;
            tr[wa - 1] = e;
        end
        if (ra > 0) begin
            while (tr.size() > ra - 1) void'(tr.pop_back());
            tr.push_back('0);
            tr.push_back('0);
        end
        policy = pol;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        foreach (tr[j]) sbq.push_back(tr[j]);
        for (int c = 1; c <= tr.size(); c++) begin
            abort = (c == ab);
            wr_en = (c == wa);
            start = (c == wa);
            if (c == wa) begin
                wr_addr = AW'($urandom);
                wr_data = (HOLD_W + 2)'($urandom);
            end
            if (ra > 0 && c == ra + 1) rst = 1'b0;
            if (c == ra) begin
                #1;
                rst = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        n = 0;
        while (sbq.size() > 0) begin
            if (n == 40) begin
                total++;
                bad++;
                $display("FAIL drain: entries left=%0d required=0", sbq.size());
                sbq.delete();
                break;
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        abort   = 1'b0;
        sbq.push_back('0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic program, readback follows the driver, then stuck at 0.
        wr_step(0, 0, 2);
        wr_step(1, 1, 0);
        wr_step(2, 2, 1);
        wr_step(3, 3, 0);
        run_prog(0, 0, 0, 0, 1'b0, 0, 0);
        run_prog(1, 0, 0, 0, 1'b0, 0, 0);

        // Step 0 is END.
        wr_step(0, 3, 0);
        run_prog(0, 0, 0, 0, 1'b0, 0, 0);

        // Full-depth program without END; write and start during the run.
        for (int a = 0; a < DEPTH; a++) wr_step(a, 1, 0);
        run_prog(0, 0, 4, 0, 1'b0, 0, 0);
        run_prog(3, 0, 0, 0, 1'b0, 0, 0);

        // Abort on the second cycle of a long drive0 step, then replay.
        wr_step(0, 0, 5);
        wr_step(1, 1, 1);
        wr_step(2, 3, 0);
        run_prog(2, 2, 0, 0, 1'b0, 0, 0);
        run_prog(2, 0, 0, 0, 1'b0, 0, 0);

        // Write to step 0 together with start, then reset mid-run.
        run_prog(1, 0, 0, 0, 1'b1, 1, 3);
        run_prog(0, 0, 0, 3, 1'b0, 0, 0);
        run_prog(3, 0, 0, 0, 1'b0, 0, 0);

        // Randomised programs, line behaviour, aborts and busy writes.
        for (int r = 0; r < 30; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int sel;
                int md;
                sel = int'($urandom_range(0, 9));
                md  = (sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 8) ? 2 : 3;
                if (a == 0 && md == 3 && $urandom_range(0, 1) == 1) md = 1;
                wr_step(a, md, int'($urandom_range(0, 3)));
            end
            run_prog(int'($urandom_range(0, 3)), -1, -1, 0, 1'b0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
